// File: rtl/chacha_pkg.sv
// chacha_pkg: shared constants and FSM encoding for the ChaCha keystream consumer.
`default_nettype none

package chacha_pkg;

  localparam int CHACHA_BLOCK_BYTES = 64;
  localparam int CTR_BITS           = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/chacha_ks_fifo.sv
// chacha_ks_fifo: byte-wide keystream FIFO with combinational head and synchronous clear.
`default_nettype none

module chacha_ks_fifo #(
  parameter int DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [7:0]             din,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only pointer-qualified entries are ever read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/counter.sv
// counter: generic up-counter with synchronous clear and increment enable.
`default_nettype none

module counter #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 inc,
  output logic [DATA_BITS-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + DATA_BITS'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/chacha_stream_xor.sv
// chacha_stream_xor: requests ChaCha keystream blocks, buffers them, and XORs them
// onto a byte stream (encrypt and decrypt are the same operation).
`default_nettype none

module chacha_stream_xor
  import chacha_pkg::*;
#(
  parameter int FIFO_DEPTH = 128
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [CTR_BITS-1:0] counter_init_i,
  output logic                block_req_o,
  output logic [CTR_BITS-1:0] counter_o,
  input  logic                ks_valid_i,
  input  logic [7:0]          ks_data_i,
  input  logic                data_valid_i,
  output logic                data_ready_o,
  input  logic [7:0]          data_i,
  input  logic                data_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [7:0]          out_data_o,
  output logic                out_last_o,
  output logic                exhausted_o,
  output logic                idle_o
);

  localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] REQ_LIMIT = CNT_W'(FIFO_DEPTH - CHACHA_BLOCK_BYTES);

  state_e              state;
  state_e              state_nxt;
  logic [CTR_BITS-1:0] ctr;
  logic                outstanding;
  logic                exhausted;
  logic [CNT_W-1:0]    fifo_count;
  logic [7:0]          fifo_head;
  logic [6:0]          byte_cnt;

  logic start_acc;
  logic req;
  logic ks_take;
  logic ks_push;
  logic blk_done;
  logic ready;
  logic accept;
  logic fifo_clear;

  always_comb begin
    start_acc  = (state == ST_IDLE) && start_i;
    req        = (state == ST_RUN) && !outstanding && !exhausted && (fifo_count <= REQ_LIMIT);
    ks_take    = ks_valid_i && outstanding;
    // Bytes of a block still in flight after the last data byte are counted but not stored.
    ks_push    = ks_take && (state != ST_FLUSH);
    blk_done   = ks_take && (byte_cnt == 7'(CHACHA_BLOCK_BYTES - 1));
    ready      = (state == ST_RUN) && (fifo_count != '0) && (!out_valid_o || out_ready_i);
    accept     = data_valid_i && ready;
    fifo_clear = start_acc || ((state == ST_FLUSH) && !outstanding);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_i) state_nxt = ST_RUN;
      ST_RUN:   if (accept && data_last_i) state_nxt = ST_FLUSH;
      ST_FLUSH: if (!outstanding) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      ctr         <= '0;
      outstanding <= 1'b0;
      exhausted   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        ctr       <= counter_init_i;
        exhausted <= 1'b0;
      end else if (req) begin
        ctr <= ctr + CTR_BITS'(1);
        // The last counter value is still served; the flag only blocks the wrap.
        if (ctr == '1) exhausted <= 1'b1;
      end
      if (req) outstanding <= 1'b1;
      else if (blk_done) outstanding <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      out_data_o  <= data_i ^ fifo_head;
      out_last_o  <= data_last_i;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  chacha_ks_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (ks_push),
    .pop   (accept),
    .clear (fifo_clear),
    .din   (ks_data_i),
    .count (fifo_count),
    .head  (fifo_head)
  );

  counter #(
    .DATA_BITS (7)
  ) u_byte_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clear (req),
    .inc   (ks_take),
    .count (byte_cnt)
  );

  assign block_req_o  = req;
  assign counter_o    = ctr;
  assign data_ready_o = ready;
  assign exhausted_o  = exhausted;
  assign idle_o       = (state == ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_chacha_stream_xor.sv
// tb_chacha_stream_xor: randomized self-checking bench with a ChaCha20 block-core model.
`default_nettype none

module tb_chacha_stream_xor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] counter_init = '0;
  logic        block_req;
  logic [31:0] counter;
  logic        ks_valid;
  logic [7:0]  ks_data;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [7:0]  data = '0;
  logic        data_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        exhausted;
  logic        idle;

  always #5 clk = ~clk;

  chacha_stream_xor #(.FIFO_DEPTH(128)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .counter_init_i(counter_init),
    .block_req_o(block_req), .counter_o(counter), .ks_valid_i(ks_valid), .ks_data_i(ks_data),
    .data_valid_i(data_valid), .data_ready_o(data_ready), .data_i(data), .data_last_i(data_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
    .exhausted_o(exhausted), .idle_o(idle)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0]  key_w [8];
  logic [31:0]  nonce_w [3];
  logic [31:0]  cs [16];
  logic [7:0]   msg [$];
  logic [7:0]   pt [$];
  logic [7:0]   ct [$];
  logic [7:0]   got [$];
  logic         got_last [$];
  logic [31:0]  req_log [$];
  logic [31:0]  pend [$];
  int           ks_pos = 0;
  logic [511:0] ks_blk;
  bit           stray_en = 1'b0;

  // ---------------- ChaCha20 reference (RFC 8439) ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic void qr(input int a, input int b, input int c, input int d);
    cs[a] = cs[a] + cs[b]; cs[d] = rotl(cs[d] ^ cs[a], 16);
    cs[c] = cs[c] + cs[d]; cs[b] = rotl(cs[b] ^ cs[c], 12);
    cs[a] = cs[a] + cs[b]; cs[d] = rotl(cs[d] ^ cs[a], 8);
    cs[c] = cs[c] + cs[d]; cs[b] = rotl(cs[b] ^ cs[c], 7);
  endfunction

  // Serialized block: byte k of the keystream lives at bits [8k+7:8k].
  function automatic logic [511:0] chacha_block(input logic [31:0] ctr);
    logic [31:0]  init [16];
    logic [511:0] r;
    init[0] = 32'h61707865; init[1] = 32'h3320646e;
    init[2] = 32'h79622d32; init[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) init[4+i] = key_w[i];
    init[12] = ctr;
    for (int i = 0; i < 3; i++) init[13+i] = nonce_w[i];
    for (int i = 0; i < 16; i++) cs[i] = init[i];
    for (int r2 = 0; r2 < 10; r2++) begin
      qr(0, 4, 8, 12); qr(1, 5, 9, 13); qr(2, 6, 10, 14); qr(3, 7, 11, 15);
      qr(0, 5, 10, 15); qr(1, 6, 11, 12); qr(2, 7, 8, 13); qr(3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = cs[i] + init[i];
    return r;
  endfunction

  // Expected keystream byte i of a message that starts at block counter ctr0.
  function automatic logic [7:0] ks_byte(input logic [31:0] ctr0, input int i);
    logic [511:0] b;
    b = chacha_block(ctr0 + 32'(i / 64));
    return b[8*(i % 64) +: 8];
  endfunction

  // ---------------- block-core model ----------------
  initial begin
    ks_valid = 1'b0;
    ks_data  = '0;
    forever begin
      @(negedge clk);
      ks_valid = 1'b0;
      if (rst_n && pend.size() != 0) begin
        if ($urandom_range(0, 3) != 0) begin
          if (ks_pos == 0) ks_blk = chacha_block(pend[0]);
          ks_valid = 1'b1;
          ks_data  = ks_blk[8*ks_pos +: 8];
          ks_pos++;
          if (ks_pos == 64) begin
            ks_pos = 0;
            void'(pend.pop_front());
          end
        end
      end else if (rst_n && stray_en) begin
        ks_valid = 1'b1;
        ks_data  = 8'($urandom);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (block_req) begin
        req_log.push_back(counter);
        pend.push_back(counter);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_key_rfc();
    for (int i = 0; i < 8; i++)
      key_w[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    nonce_w[0] = 32'h0; nonce_w[1] = 32'h4a000000; nonce_w[2] = 32'h0;
  endtask

  task automatic set_key_random();
    for (int i = 0; i < 8; i++) key_w[i] = $urandom;
    for (int i = 0; i < 3; i++) nonce_w[i] = $urandom;
  endtask

  task automatic random_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  task automatic start_msg(input logic [31:0] c);
    req_log.delete();
    @(negedge clk);
    counter_init = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int cyc = 0;
    while (!idle && cyc < max_cyc) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  // Drives msg[0..n-1], collects outputs, and checks output stability under stall.
  task automatic run_data(input int n, input bit bp, input bit mark_last, input int max_cyc,
                          output int sent);
    int         idx = 0;
    int         cyc = 0;
    bit         hold = 1'b0;
    logic [7:0] hold_data = '0;
    got.delete();
    got_last.delete();
    while (got.size() < n && cyc < max_cyc) begin
      @(negedge clk);
      out_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      data_valid = (idx < n);
      data       = (idx < n) ? msg[idx] : 8'h00;
      data_last  = mark_last && (idx == n - 1);
      #1;
      if (hold) begin
        checks++;
        if (out_data !== hold_data) begin
          errors++;
          $display("FAIL hold_stable: out_data=%h while stalled, required %h", out_data, hold_data);
        end
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (data_valid && data_ready) idx++;
      cyc++;
    end
    @(negedge clk);
    data_valid = 1'b0;
    data_last  = 1'b0;
    out_ready  = 1'b1;
    sent = idx;
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    start = 1'b0;
    data_valid = 1'b0;
    data_last = 1'b0;
    out_ready = 1'b1;
    pend.delete();
    ks_pos = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({block_req, counter, data_ready, out_valid, out_data, out_last, exhausted, idle} !==
        {1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: req=%b ctr=%h rdy=%b ov=%b od=%h ol=%b exh=%b idle=%b, required 0 0 0 0 0 0 0 1",
               block_req, counter, data_ready, out_valid, out_data, out_last, exhausted, idle);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rfc_encrypt();
    string s;
    int    sent, bad, lbad;
    logic [7:0] exp;
    s = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
    set_key_rfc();
    pt.delete();
    for (int i = 0; i < s.len(); i++) pt.push_back(s[i]);
    msg = pt;
    start_msg(32'd1);
    #1;
    checks++;
    if (block_req !== 1'b1 || counter !== 32'd1) begin
      errors++;
      $display("FAIL first_request: req=%b counter=%h, required 1 and 00000001", block_req, counter);
    end
    run_data(pt.size(), 1'b0, 1'b1, 2000, sent);
    bad = 0;
    lbad = 0;
    for (int i = 0; i < got.size(); i++) begin
      exp = pt[i] ^ ks_byte(32'd1, i);
      if (got[i] !== exp) bad++;
      if (got_last[i] !== (i == pt.size() - 1)) lbad++;
    end
    checks++;
    if (bad != 0 || got.size() != pt.size()) begin
      errors++;
      $display("FAIL rfc_ciphertext: %0d wrong of %0d received, required 0 wrong of %0d", bad, got.size(), pt.size());
    end
    checks++;
    if (got.size() < 4 || {got[0], got[1], got[2], got[3]} !== 32'h6e2e359a) begin
      errors++;
      $display("FAIL rfc_anchor: first ciphertext bytes wrong (received %0d bytes), required 6e2e359a", got.size());
    end
    checks++;
    if (lbad != 0) begin
      errors++;
      $display("FAIL rfc_last: %0d bytes with wrong out_last, required 0", lbad);
    end
    wait_idle(400);
    checks++;
    if (idle !== 1'b1 || pend.size() != 0) begin
      errors++;
      $display("FAIL rfc_idle: idle=%b pending_blocks=%0d, required 1 and 0", idle, pend.size());
    end
    checks++;
    if (req_log.size() != 2 || req_log[0] !== 32'd1 || req_log[1] !== 32'd2) begin
      errors++;
      $display("FAIL rfc_requests: %0d requests, required exactly 2 (counters 1,2)", req_log.size());
    end
    ct = got;
  endtask

  task automatic test_rfc_decrypt_backpressure();
    int sent, bad;
    msg = ct;
    start_msg(32'd1);
    run_data(ct.size(), 1'b1, 1'b1, 3000, sent);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== pt[i]) bad++;
    checks++;
    if (bad != 0 || got.size() != pt.size()) begin
      errors++;
      $display("FAIL decrypt_plaintext: %0d wrong of %0d received, required 0 wrong of %0d", bad, got.size(), pt.size());
    end
    wait_idle(400);
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL decrypt_idle: idle=%b, required 1", idle);
    end
  endtask

  task automatic test_random_back_to_back();
    int          n, sent, bad, rbad;
    logic [31:0] c0;
    for (int t = 0; t < 3; t++) begin
      set_key_random();
      n  = $urandom_range(1, 300);
      c0 = $urandom_range(0, 32'h7fffffff);
      random_msg(n);
      start_msg(c0);
      run_data(n, 1'b1, 1'b1, 4000, sent);
      bad = 0;
      for (int i = 0; i < got.size(); i++)
        if (got[i] !== (msg[i] ^ ks_byte(c0, i))) bad++;
      checks++;
      if (bad != 0 || got.size() != n) begin
        errors++;
        $display("FAIL random_data[%0d]: %0d wrong of %0d received, required 0 wrong of %0d", t, bad, got.size(), n);
      end
      wait_idle(400);
      rbad = (req_log.size() < (n + 63) / 64) ? 1 : 0;
      for (int k = 0; k < req_log.size(); k++) if (req_log[k] !== c0 + 32'(k)) rbad++;
      checks++;
      if (rbad != 0 || idle !== 1'b1) begin
        errors++;
        $display("FAIL random_requests[%0d]: %0d bad of %0d requests, idle=%b, required 0 bad and idle 1", t, rbad, req_log.size(), idle);
      end
    end
  endtask

  task automatic test_exhaustion();
    int sent, bad;
    set_key_random();
    random_msg(200);
    start_msg(32'hFFFFFFFE);
    run_data(200, 1'b0, 1'b1, 800, sent);
    bad = 0;
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== (msg[i] ^ ks_byte(32'hFFFFFFFE, i))) bad++;
    checks++;
    if (bad != 0 || got.size() != 128) begin
      errors++;
      $display("FAIL exhaust_data: %0d wrong of %0d received, required 0 wrong of 128", bad, got.size());
    end
    checks++;
    if (sent != 128) begin
      errors++;
      $display("FAIL exhaust_accepted: %0d input bytes accepted, required 128", sent);
    end
    #1;
    checks++;
    if (data_ready !== 1'b0 || exhausted !== 1'b1) begin
      errors++;
      $display("FAIL exhaust_flags: data_ready=%b exhausted=%b, required 0 and 1", data_ready, exhausted);
    end
    checks++;
    if (req_log.size() != 2 || req_log[0] !== 32'hFFFFFFFE || req_log[1] !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL exhaust_requests: %0d requests, required exactly 2 (fffffffe, ffffffff)", req_log.size());
    end
    do_reset();
  endtask

  task automatic test_reset_mid_block();
    int          sent, cyc, bad;
    logic [31:0] c0;
    set_key_random();
    c0 = $urandom;
    random_msg(80);
    start_msg(c0);
    run_data(5, 1'b0, 1'b0, 500, sent);
    out_ready  = 1'b0;
    data_valid = 1'b1;
    data       = msg[5];
    cyc = 0;
    while (ks_pos != 30 && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cyc >= 400 || {block_req, counter, data_ready, out_valid, out_data, out_last, exhausted, idle} !==
        {1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_async: req=%b ctr=%h rdy=%b ov=%b od=%h ol=%b exh=%b idle=%b wait=%0d, required 0 0 0 0 0 0 0 1",
               block_req, counter, data_ready, out_valid, out_data, out_last, exhausted, idle, cyc);
    end
    data_valid = 1'b0;
    out_ready  = 1'b1;
    pend.delete();
    ks_pos = 0;
    @(negedge clk);
    rst_n = 1'b1;
    c0 = $urandom_range(0, 32'h7fffffff);
    random_msg(100);
    start_msg(c0);
    run_data(100, 1'b0, 1'b1, 2000, sent);
    bad = 0;
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== (msg[i] ^ ks_byte(c0, i))) bad++;
    checks++;
    if (bad != 0 || got.size() != 100) begin
      errors++;
      $display("FAIL after_reset_data: %0d wrong of %0d received, required 0 wrong of 100", bad, got.size());
    end
    wait_idle(400);
  endtask

  task automatic test_ignore_start_stray();
    int          sent, cyc, bad;
    logic [31:0] c0;
    set_key_random();
    c0 = $urandom_range(0, 32'h7fffffff);
    random_msg(150);
    stray_en = 1'b1;
    start_msg(c0);
    cyc = 0;
    while (!(req_log.size() == 2 && pend.size() == 0) && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    repeat (20) @(negedge clk);
    counter_init = c0 + 32'h1000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (idle !== 1'b0 || cyc >= 600) begin
      errors++;
      $display("FAIL start_ignored: idle=%b prime_wait=%0d, required idle 0", idle, cyc);
    end
    run_data(150, 1'b1, 1'b1, 3000, sent);
    bad = 0;
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== (msg[i] ^ ks_byte(c0, i))) bad++;
    checks++;
    if (bad != 0 || got.size() != 150) begin
      errors++;
      $display("FAIL stray_data: %0d wrong of %0d received, required 0 wrong of 150", bad, got.size());
    end
    wait_idle(400);
    bad = 0;
    for (int k = 0; k < req_log.size(); k++) if (req_log[k] !== c0 + 32'(k)) bad++;
    checks++;
    if (bad != 0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL stray_requests: %0d bad of %0d requests, idle=%b, required 0 bad and idle 1", bad, req_log.size(), idle);
    end
    stray_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rfc_encrypt();
    test_rfc_decrypt_backpressure();
    test_random_back_to_back();
    test_exhaustion();
    test_reset_mid_block();
    test_ignore_start_stray();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
